// File: rtl/wrr_packet_arbiter_pkg.sv
// Shared router definitions for the weighted round-robin packet arbiter:
// default sizes, arbiter state encoding and pointer-width helper.
package wrr_packet_arbiter_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_WEIGHT_W = 4;

    localparam logic [0:0] ARB_IDLE_ENC = 1'b0;
    localparam logic [0:0] ARB_LOCK_ENC = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE = ARB_IDLE_ENC,
        ARB_LOCK = ARB_LOCK_ENC
    } arb_state_e;

    function automatic int calc_ptr_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/wrr_packet_arbiter_chk.sv
// Protocol checker for the arbiter outputs: one-hot grant and a stable
// grant for the whole of a locked packet.
module wrr_packet_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst_n,
    input logic [NUM_REQ-1:0] i_grant,
    input logic               i_out_valid,
    input logic               i_out_ready,
    input logic               i_out_last
);

    logic               r_locked;
    logic [NUM_REQ-1:0] r_grant_q;

    // track whether a packet is open and who opened it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_locked  <= 1'b0;
            r_grant_q <= '0;
        end else if (i_out_valid && i_out_ready) begin
            r_locked  <= !i_out_last;
            r_grant_q <= i_grant;
        end
    end

    // property checks, skipped while reset is applied
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(i_grant))
                else $error("chk: grant not one-hot-or-zero: %b", i_grant);
            if (r_locked) begin
                assert (i_grant == r_grant_q)
                    else $error("chk: grant changed inside packet: %b vs %b", i_grant, r_grant_q);
            end
        end
    end

endmodule

// File: rtl/wrr_packet_arbiter_rr_pick.sv
// Combinational priority picker: lowest requester at or above i_ptr,
// otherwise lowest requester overall.
module wrr_packet_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx
);

    logic w_hit;

    // masked search, falling back to an unmasked search on a miss
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_hit   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_hit && i_req[i] && (PTR_W'(i) >= i_ptr)) begin
                w_hit      = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
            end else begin
                w_hit = w_hit;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_hit && i_req[i]) begin
                w_hit      = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
            end else begin
                w_hit = w_hit;
            end
        end
    end

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter: grants one channel per packet with
// zero-latency handshake; a winner keeps priority for weight[i] packets.
module wrr_packet_arbiter
    import wrr_packet_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int WEIGHT_W = DEF_WEIGHT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_arb_enable,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_last,
    input  logic [NUM_REQ*WEIGHT_W-1:0] i_weight,
    input  logic                        i_out_ready,
    output logic                        o_out_valid,
    output logic                        o_out_last,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [NUM_REQ-1:0]          o_req_ready
);

    localparam int PTR_W = calc_ptr_w(NUM_REQ);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [PTR_W-1:0]    r_last_owner;
    logic                r_last_owner_vld;
    logic [WEIGHT_W-1:0] r_credit;

    logic [PTR_W-1:0]    w_pick_ptr;
    logic [PTR_W-1:0]    w_pick_idx;
    logic [PTR_W-1:0]    w_cur_idx;
    logic [PTR_W-1:0]    w_ptr_adv;
    logic [NUM_REQ-1:0]  w_pick_grant;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [WEIGHT_W-1:0] w_sel_weight;
    logic [WEIGHT_W-1:0] w_load_val;
    logic [WEIGHT_W-1:0] w_credit_now;
    logic                w_xfer;
    logic                w_load;

    // fixed priority is the same search anchored at channel 0
    assign w_pick_ptr = i_arb_enable ? r_ptr : {PTR_W{1'b0}};

    wrr_packet_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_cur_idx = (r_state == ARB_LOCK) ? r_owner : w_pick_idx;

    always_comb begin
        w_owner_oh   = '0;
        w_sel_weight = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == r_owner) begin
                w_owner_oh[i] = 1'b1;
            end else begin
                w_owner_oh[i] = 1'b0;
            end
            if (PTR_W'(i) == w_cur_idx) begin
                w_sel_weight = i_weight[i*WEIGHT_W +: WEIGHT_W];
            end else begin
                w_sel_weight = w_sel_weight;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        if (!rst_n) begin
            o_grant = '0;
        end else if (r_state == ARB_LOCK) begin
            o_grant = w_owner_oh;
        end else begin
            o_grant = w_pick_grant;
        end
    end

    assign o_out_valid = |(o_grant & i_req_valid);
    assign o_out_last  = |(o_grant & i_req_last);
    assign o_req_ready = o_grant & {NUM_REQ{i_out_ready}};
    assign w_xfer      = o_out_valid & i_out_ready;

    // a fresh turn starts whenever the winner is not the channel holding credit
    always_comb begin
        w_ptr_adv    = '0;
        w_load_val   = '0;
        w_load       = (r_state == ARB_IDLE) && (!r_last_owner_vld || (w_cur_idx != r_last_owner));
        if (w_cur_idx == PTR_W'(NUM_REQ - 1)) begin
            w_ptr_adv = '0;
        end else begin
            w_ptr_adv = w_cur_idx + PTR_W'(1);
        end
        if (w_sel_weight == {WEIGHT_W{1'b0}}) begin
            w_load_val = '0;
        end else begin
            w_load_val = w_sel_weight - WEIGHT_W'(1);
        end
        if (w_load) begin
            w_credit_now = w_load_val;
        end else begin
            w_credit_now = r_credit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_xfer && !o_out_last) begin
                    w_state_nxt = ARB_LOCK;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_LOCK: begin
                if (w_xfer && o_out_last) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_state_nxt = ARB_LOCK;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // owner capture and, in weighted mode only, pointer/credit bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr            <= '0;
            r_owner          <= '0;
            r_last_owner     <= '0;
            r_last_owner_vld <= 1'b0;
            r_credit         <= '0;
        end else begin
            if (w_xfer && (r_state == ARB_IDLE) && !o_out_last) begin
                r_owner <= w_cur_idx;
            end
            if (i_arb_enable && w_xfer) begin
                if (o_out_last) begin
                    if (w_credit_now == {WEIGHT_W{1'b0}}) begin
                        r_ptr            <= w_ptr_adv;
                        r_last_owner_vld <= 1'b0;
                        r_credit         <= '0;
                    end else begin
                        r_ptr            <= w_cur_idx;
                        r_credit         <= w_credit_now - WEIGHT_W'(1);
                        r_last_owner     <= w_cur_idx;
                        r_last_owner_vld <= 1'b1;
                    end
                end else if (w_load) begin
                    r_credit         <= w_load_val;
                    r_last_owner     <= w_cur_idx;
                    r_last_owner_vld <= 1'b1;
                end
            end
        end
    end

endmodule
